// File: rtl/lilme_pkg.sv
// Shared definitions for the LilME result path: chunk/word geometry,
// collector state encoding and frame sizing.
package lilme_pkg;

  localparam int CHUNKS_PER_WORD = 8;
  localparam int CHUNK_W         = 32;
  localparam int RESULT_W        = CHUNKS_PER_WORD * CHUNK_W;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } collector_state_e;

  // One frame carries both halves of the product, hence two words per row.
  function automatic int words_per_frame(input int rows);
    return 2 * rows;
  endfunction

endpackage

// File: rtl/lilme_result_collector_if.sv
// Chunk input and word output bundle of the result collector.
// The slave side is the collector, the master side drives chunks and consumes words.
interface lilme_result_collector_if
  import lilme_pkg::*;
#(
  parameter int dw         = 31,
  parameter int fifo_depth = 4
);

  logic                                  chunk_valid;
  logic [dw:0]                           chunk_data;
  logic                                  frame_abort;
  logic                                  word_valid;
  logic [CHUNKS_PER_WORD*(dw+1)-1:0]     word_data;
  logic                                  word_last;
  logic                                  word_ready;
  logic                                  frame_done;
  logic                                  overflow;
  logic                                  clear_overflow;
  logic [$clog2(fifo_depth):0]           level;
  logic                                  busy;

  modport slave (
    input  chunk_valid, chunk_data, frame_abort, word_ready, clear_overflow,
    output word_valid, word_data, word_last, frame_done, overflow, level, busy
  );

  modport master (
    output chunk_valid, chunk_data, frame_abort, word_ready, clear_overflow,
    input  word_valid, word_data, word_last, frame_done, overflow, level, busy
  );

endinterface

// File: rtl/lilme_word_fifo.sv
// Small synchronous word FIFO with occupancy count; a push is accepted
// while full when a pop happens in the same cycle.
module lilme_word_fifo
  import lilme_pkg::*;
#(
  parameter  int WIDTH = RESULT_W + 1,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LEVEL);
  assign level_o = level_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head reads as zero whenever nothing is queued, so stale storage never leaks out.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lilme_result_collector.sv
// Reassembles controller result chunks into product words, tracks frame
// position and queues finished words for the downstream consumer.
module lilme_result_collector
  import lilme_pkg::*;
#(
  parameter int dw         = 31,
  parameter int row        = 4,
  parameter int fifo_depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  lilme_result_collector_if.slave  bus
);

  localparam int CW  = dw + 1;
  localparam int WW  = CHUNKS_PER_WORD * CW;
  localparam int IW  = $clog2(CHUNKS_PER_WORD);
  localparam int WPF = words_per_frame(row);
  localparam int WIW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int LW  = $clog2(fifo_depth) + 1;

  localparam logic [IW-1:0]  LAST_CHUNK = IW'(CHUNKS_PER_WORD - 1);
  localparam logic [WIW-1:0] LAST_WORD  = WIW'(WPF - 1);

  collector_state_e state_q, state_d;
  logic [IW-1:0]    chunk_idx_q, chunk_idx_d;
  logic [WIW-1:0]   word_idx_q, word_idx_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;
  logic [CW-1:0]    slot_q [CHUNKS_PER_WORD-1];

  logic             push, push_last, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [WW-1:0]    push_word;
  logic [WW:0]      head;
  logic [LW-1:0]    fifo_level;

  // The closing chunk goes straight into the word without passing through a slot.
  always_comb begin
    push_word = '0;
    for (int k = 0; k < CHUNKS_PER_WORD - 1; k++) begin
      push_word[k*CW +: CW] = slot_q[k];
    end
    push_word[WW-1 -: CW] = bus.chunk_data;
  end

  always_comb begin
    state_d     = state_q;
    chunk_idx_d = chunk_idx_q;
    word_idx_d  = word_idx_q;
    push        = 1'b0;
    push_last   = 1'b0;
    if (bus.frame_abort) begin
      state_d     = ST_IDLE;
      chunk_idx_d = '0;
      word_idx_d  = '0;
    end else if (bus.chunk_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          chunk_idx_d = chunk_idx_q + 1'b1;
          state_d     = ST_ASSEMBLE;
        end
        ST_ASSEMBLE: begin
          if (chunk_idx_q == LAST_CHUNK) begin
            push        = 1'b1;
            push_last   = (word_idx_q == LAST_WORD);
            chunk_idx_d = '0;
            state_d     = ST_IDLE;
            // Advances even on a dropped word so frame alignment survives overflow.
            word_idx_d  = push_last ? '0 : word_idx_q + 1'b1;
          end else begin
            chunk_idx_d = chunk_idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pop          = !fifo_empty && bus.word_ready;
  assign drop         = push && fifo_full && !pop;
  assign frame_done_d = push && push_last && !drop;

  // A fresh drop wins over a simultaneous clear so no loss goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)                    overflow_d = 1'b1;
    else if (bus.clear_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      chunk_idx_q  <= '0;
      word_idx_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chunk_idx_q  <= chunk_idx_d;
      word_idx_q   <= word_idx_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.chunk_valid && !bus.frame_abort && chunk_idx_q != LAST_CHUNK) begin
      slot_q[chunk_idx_q] <= bus.chunk_data;
    end
  end

  lilme_word_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({push_last, push_word}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bus.word_valid = !fifo_empty;
  assign bus.word_data  = head[WW-1:0];
  assign bus.word_last  = head[WW];
  assign bus.level      = fifo_level;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q == ST_ASSEMBLE);

endmodule

// File: tb/tb_lilme_result_collector.sv
// Scenario and randomized checks of the result collector against a
// queue-based model of chunk grouping, frame position and word buffering.
module tb_lilme_result_collector;
  import lilme_pkg::*;

  localparam int DW    = 31;
  localparam int ROW   = 4;
  localparam int DEPTH = 4;
  localparam int WPF   = 2 * ROW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lilme_result_collector_if #(.dw(DW), .fifo_depth(DEPTH)) bus ();

  lilme_result_collector #(.dw(DW), .row(ROW), .fifo_depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [255:0] data;
    logic         last;
  } word_t;

  word_t       mq[$];
  logic [31:0] cbuf[$];
  int          widx;
  bit          m_ovf;
  bit          m_fd;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [255:0] make_word(input logic [31:0] base);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = base + k;
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    cbuf.delete();
    widx  = 0;
    m_ovf = 0;
    m_fd  = 0;
  endtask

  task automatic drive_idle_inputs();
    bus.chunk_valid    = 1'b0;
    bus.chunk_data     = '0;
    bus.frame_abort    = 1'b0;
    bus.word_ready     = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then settle past the edge.
  task automatic step(input bit cv, input logic [31:0] cd, input bit ab,
                      input bit rdy, input bit clr);
    word_t w;
    bit    drop;
    bus.chunk_valid    = cv;
    bus.chunk_data     = cd;
    bus.frame_abort    = ab;
    bus.word_ready     = rdy;
    bus.clear_overflow = clr;
    drop = 0;
    m_fd = 0;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (ab) begin
      cbuf.delete();
      widx = 0;
    end else if (cv) begin
      cbuf.push_back(cd);
      if (cbuf.size() == 8) begin
        w.data = '0;
        for (int k = 0; k < 8; k++) w.data[32*k +: 32] = cbuf[k];
        w.last = (widx == WPF - 1);
        widx   = (widx + 1) % WPF;
        cbuf.delete();
        if (mq.size() < DEPTH) begin
          mq.push_back(w);
          m_fd = w.last;
        end else begin
          drop = 1;
        end
      end
    end
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.word_valid, bus.word_last, bus.frame_done, bus.overflow, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b l=%b fd=%b ov=%b busy=%b, expected all 0",
               bus.word_valid, bus.word_last, bus.frame_done, bus.overflow, bus.busy);
    end
    checks++;
    if (bus.level !== 0) begin
      errors++;
      $display("FAIL reset_level: got %0d expected 0", bus.level);
    end
    checks++;
    if (bus.word_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", bus.word_data);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, i, 0, 1, 0);
      if (i < 7) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.word_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_partial[%0d]: got busy=%b valid=%b expected busy=1 valid=0",
                   i, bus.busy, bus.word_valid);
        end
      end
    end
    checks++;
    if (bus.word_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got %b expected 1", bus.word_valid);
    end
    checks++;
    if (bus.word_data[31:0] !== 32'h0 || bus.word_data[255:224] !== 32'h7) begin
      errors++;
      $display("FAIL single_edges: got lo=%h hi=%h expected lo=0 hi=7",
               bus.word_data[31:0], bus.word_data[255:224]);
    end
    checks++;
    if (bus.word_data !== make_word(0) || bus.word_last !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_word: got data=%h last=%b busy=%b expected data=%h last=0 busy=0",
               bus.word_data, bus.word_last, bus.busy, make_word(0));
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (bus.level !== 0 || bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got level=%0d valid=%b expected level=0 valid=0",
               bus.level, bus.word_valid);
    end
  endtask

  task automatic test_full_frame();
    int fd_cnt, last_cnt, nwords;
    apply_reset();
    fd_cnt = 0; last_cnt = 0; nwords = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, i, 0, 1, 0);
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.word_valid === 1'b1) begin
        nwords++;
        if (bus.word_last === 1'b1) last_cnt++;
        checks++;
        if (bus.word_data !== make_word(8 * (nwords - 1)) || bus.word_last !== (nwords == 8)) begin
          errors++;
          $display("FAIL frame_word[%0d]: got data=%h last=%b expected data=%h last=%b",
                   nwords - 1, bus.word_data, bus.word_last, make_word(8 * (nwords - 1)),
                   nwords == 8);
        end
      end
    end
    step(0, 0, 0, 1, 0);
    if (bus.frame_done === 1'b1) fd_cnt++;
    checks++;
    if (nwords !== 8 || fd_cnt !== 1 || last_cnt !== 1) begin
      errors++;
      $display("FAIL frame_counts: got words=%0d frame_done=%0d last=%0d expected 8/1/1",
               nwords, fd_cnt, last_cnt);
    end
    for (int i = 64; i < 72; i++) step(1, i, 0, 1, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_last !== 1'b0 || bus.word_data !== make_word(64)) begin
      errors++;
      $display("FAIL frame_ninth: got valid=%b last=%b data=%h expected valid=1 last=0 data=%h",
               bus.word_valid, bus.word_last, bus.word_data, make_word(64));
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 40; i++) step(1, i, 0, 0, 0);
    checks++;
    if (bus.level !== 4 || bus.overflow !== 1'b1 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill: got level=%0d overflow=%b fd=%b expected level=4 overflow=1 fd=0",
               bus.level, bus.overflow, bus.frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.word_data !== make_word(8 * k) || bus.word_last !== 1'b0) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: got data=%h last=%b expected data=%h last=0",
                 k, bus.word_data, bus.word_last, make_word(8 * k));
      end
      step(0, 0, 0, 1, 0);
    end
    checks++;
    if (bus.level !== 0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got level=%0d overflow=%b expected level=0 overflow=1",
               bus.level, bus.overflow);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", bus.overflow);
    end
    for (int w = 0; w < 3; w++) begin
      for (int j = 0; j < 8; j++) step(1, 1000 + 8 * w + j, 0, 1, 0);
      checks++;
      if (bus.word_last !== (w == 2) || bus.frame_done !== (w == 2) ||
          bus.word_data !== make_word(1000 + 8 * w)) begin
        errors++;
        $display("FAIL ovf_align[%0d]: got last=%b fd=%b data=%h expected last=%b fd=%b data=%h",
                 w, bus.word_last, bus.frame_done, bus.word_data, w == 2, w == 2,
                 make_word(1000 + 8 * w));
      end
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 39; i++) step(1, 2000 + i, 0, 0, 0);
    checks++;
    if (bus.level !== 4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL pp_full: got level=%0d overflow=%b expected level=4 overflow=0",
               bus.level, bus.overflow);
    end
    step(1, 2039, 0, 1, 0);
    checks++;
    if (bus.level !== 4 || bus.overflow !== 1'b0 || bus.word_data !== make_word(2008)) begin
      errors++;
      $display("FAIL pp_same_cycle: got level=%0d overflow=%b head=%h expected level=4 overflow=0 head=%h",
               bus.level, bus.overflow, bus.word_data, make_word(2008));
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.word_data !== make_word(2000 + 8 * k)) begin
        errors++;
        $display("FAIL pp_order[%0d]: got %h expected %h", k, bus.word_data, make_word(2000 + 8 * k));
      end
      step(0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_abort();
    int nwords;
    apply_reset();
    for (int i = 0; i < 16; i++) step(1, 500 + i, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 600 + i, 0, 1, 0);
    step(1, 32'hdead_beef, 1, 1, 0);
    checks++;
    if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0 || bus.level !== 0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b valid=%b level=%0d expected 0/0/0",
               bus.busy, bus.word_valid, bus.level);
    end
    nwords = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 3000 + i, 0, 1, 0);
      if (bus.word_valid === 1'b1) begin
        checks++;
        if (bus.word_data !== make_word(3000 + 8 * nwords) || bus.word_last !== (nwords == 7)) begin
          errors++;
          $display("FAIL abort_frame[%0d]: got data=%h last=%b expected data=%h last=%b",
                   nwords, bus.word_data, bus.word_last, make_word(3000 + 8 * nwords), nwords == 7);
        end
        nwords++;
      end
    end
    checks++;
    if (nwords !== 8) begin
      errors++;
      $display("FAIL abort_count: got %0d words expected 8", nwords);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 21; i++) step(1, 700 + i, 0, 0, 0);
    checks++;
    if (bus.level !== 2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: got level=%0d busy=%b expected level=2 busy=1", bus.level, bus.busy);
    end
    drive_idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.word_valid, bus.word_last, bus.frame_done, bus.overflow, bus.busy} !== 5'b0 ||
        bus.level !== 0 || bus.word_data !== '0) begin
      errors++;
      $display("FAIL rmid_async: got v=%b l=%b fd=%b ov=%b busy=%b level=%0d data=%h expected all 0",
               bus.word_valid, bus.word_last, bus.frame_done, bus.overflow, bus.busy,
               bus.level, bus.word_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1, 4000 + i, 0, 1, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.level !== 1 || bus.word_last !== 1'b0 ||
        bus.word_data !== make_word(4000)) begin
      errors++;
      $display("FAIL rmid_after: got valid=%b level=%0d last=%b data=%h expected 1/1/0/%h",
               bus.word_valid, bus.level, bus.word_last, bus.word_data, make_word(4000));
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit cv, ab, rdy, clr;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      cv  = ($urandom_range(0, 9) < 8);
      ab  = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 31) == 0);
      step(cv, $urandom, ab, rdy, clr);
      checks++;
      if (bus.word_valid !== (mq.size() > 0) || bus.level !== mq.size() ||
          bus.overflow !== m_ovf || bus.frame_done !== m_fd || bus.busy !== (cbuf.size() > 0)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got v=%b lvl=%0d ov=%b fd=%b busy=%b expected v=%b lvl=%0d ov=%b fd=%b busy=%b",
                 c, bus.word_valid, bus.level, bus.overflow, bus.frame_done, bus.busy,
                 mq.size() > 0, mq.size(), m_ovf, m_fd, cbuf.size() > 0);
      end
      if (mq.size() > 0) begin
        checks++;
        if (bus.word_data !== mq[0].data || bus.word_last !== mq[0].last) begin
          errors++;
          $display("FAIL rand_head[%0d]: got data=%h last=%b expected data=%h last=%b",
                   c, bus.word_data, bus.word_last, mq[0].data, mq[0].last);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_overflow();
    test_full_push_pop();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lilme_result_collector.md
# lilme_result_collector

Receiving end of the LilME controller's result stream. It accepts the 32-bit result chunks the controller emits during its read-out states, reassembles each group of 8 chunks into one 256-bit product word, and tracks frames of 2*row words. Completed words are buffered in a small FIFO and presented to the downstream consumer over a valid/ready interface. It sits between the controller's Data_out/Busy pins and the host or scoreboard side.

## Interface
- dw, 31: chunk MSB index; chunk width is dw+1 = 32.
- row, 4: matrix rows; one frame is 2*row words.
- fifo_depth, 4: word FIFO entries, power of two, at least 2.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- chunk_valid  in  1  chunk_data is a result chunk this cycle (decoded from controller DATA_OUT/READ_MULTIPLY).
- chunk_data  in  dw+1  result chunk; chunk k of a word is bits [32k+31:32k].
- frame_abort  in  1  discards the partial word and resets the frame position; FIFO contents are kept.
- word_valid  out  1  FIFO head is valid.
- word_data  out  8*(dw+1)  FIFO head word.
- word_last  out  1  FIFO head is word 2*row-1 of its frame.
- word_ready  in  1  consumer accepts the head when word_valid is also high.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written into the FIFO.
- overflow  out  1  sticky; a completed word was dropped.
- clear_overflow  in  1  clears overflow synchronously.
- level  out  $clog2(fifo_depth)+1  current FIFO occupancy.
- busy  out  1  a partial word is being assembled.

## Operation
- States: IDLE (chunk_idx=0, no partial), ASSEMBLE (1 to 7 chunks held).
- IDLE: chunk_valid stores the chunk in slot 0, chunk_idx becomes 1, next state ASSEMBLE.
- ASSEMBLE: chunk_valid stores the chunk in slot chunk_idx. When chunk_idx==7, the full word (slots 0-6 plus the current chunk) is pushed, chunk_idx becomes 0, and the next state is IDLE. Otherwise chunk_idx increments.
- word_idx counts pushed words 0..2*row-1 and wraps to 0 after the last word. The pushed word carries last = (word_idx==2*row-1). frame_done pulses on that push.
- Push with the FIFO full and no simultaneous pop: the word is dropped, overflow sets, and word_idx still advances so frame alignment is preserved.
- Push and pop in the same cycle while full: both happen, with no overflow.
- frame_abort takes priority over chunk_valid: chunk_idx=0, word_idx=0, state IDLE, no push.
- clear_overflow in the same cycle as a new drop leaves overflow set.
- Chunks pass through unmodified; no arithmetic is done on the data.

## Timing
- Reset values: word_valid=0, word_data=0, word_last=0, frame_done=0, overflow=0, level=0, busy=0. Internal chunk_idx=0, word_idx=0, state IDLE.
- Latency: the 8th chunk is sampled at edge N. The word is in the FIFO and word_valid=1 after edge N. frame_done is registered and high in the cycle after edge N.
- Throughput: one chunk per cycle, sustained indefinitely with no bubbles. No backpressure reaches the controller.
- Pop happens at an edge where word_valid && word_ready. level reflects push and pop after that edge.
- word_data and word_last hold stable while word_valid=1 and the word has not been popped.
- busy = (state==ASSEMBLE), registered.
- Reset mid-word or mid-frame discards everything, including the FIFO.

## Structure
- Shared package lilme_pkg holds: CHUNKS_PER_WORD=8, RESULT_W=256, CHUNK_W=32, the collector state enum, and the words-per-frame function 2*row.
- Sub-module lilme_word_fifo: synchronous FIFO of width RESULT_W+1 (data plus last), with full/empty/level outputs and simultaneous push/pop support when full.
- The top level holds the chunk assembler FSM, word_idx counter, overflow logic and frame_done register.

## Test plan
- Reset, then 8 chunks 0x0..0x7 with word_ready=1 -> word_data bits [31:0]=0, [255:224]=7. word_valid high one cycle after the 8th chunk. word_last=0, level returns to 0.
- Full frame of 64 consecutive chunks (value = index) with word_ready=1 -> 8 words out. Only the 8th word has word_last=1. frame_done pulses exactly once. The 9th word starts at word_idx 0.
- word_ready=0 with 5 words sent at fifo_depth=4 -> level=4, overflow=1 after the 5th push. Draining yields words 0-3. The next frame's word_last lands on the correct word.
- FIFO full with a push and pop in the same cycle -> level stays 4, overflow stays 0, and the popped word is the oldest.
- 3 chunks, then frame_abort asserted together with chunk_valid -> busy=0, nothing pushed. The next 8 chunks form a clean word 0 of a new frame.
- Reset asserted after 5 chunks with 2 words queued -> all outputs return to reset values immediately. Subsequent 8 chunks produce one correct word.
